// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: 25 MHz pixel strobe from the 50 MHz clock, scan counters, syncs, frame tick.
// Latency: hsync/vsync/frame_tick registered from next-state counts, so they align with pixel_x/pixel_y; no backpressure.
module vga_sync_gen #(
    parameter int   H_DISP   = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_DISP   = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       frame_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic       div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ft_q, ft_d;

    always_comb begin
        div_d = ~div_q;
        h_d   = h_q;
        v_d   = v_q;
        // >= rather than == so a corrupted count recovers to 0 on the next tick
        if (div_q) begin
            if (h_q >= H_LAST) begin
                h_d = '0;
                if (v_q >= V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_comb begin
        hs_d = ~SYNC_POL;
        vs_d = ~SYNC_POL;
        if ((h_d >= HS_START) && (h_d <= HS_END)) begin
            hs_d = SYNC_POL;
        end
        if ((v_d >= VS_START) && (v_d <= VS_END)) begin
            vs_d = SYNC_POL;
        end
        // Fires in the cycle whose strobe retires the last pixel of the frame
        ft_d = div_d && (h_d == H_LAST) && (v_d == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            ft_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ft_q  <= ft_d;
        end
    end

    assign p_tick     = div_q;
    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign frame_tick = ft_q;
    assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, shrunk active-high instance for frame timing.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       pt;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    localparam int S_HT = 14;
    localparam int S_VT = 7;
    localparam int S_FRAME_CLKS = 2 * S_HT * S_VT;

    logic clk = 1'b0;
    logic rst_d_n = 1'b0;
    logic rst_s_n = 1'b0;

    logic       d_hs, d_vs, d_von, d_pt, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_von, s_pt, s_ft;
    logic [9:0] s_x, s_y;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t qd[$];
    exp_t qs[$];
    int   cd = 0, cs = 0;
    bit   d_ok = 0, s_ok = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_dut_full (
        .clk(clk), .reset_n(rst_d_n), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .p_tick(d_pt), .frame_tick(d_ft), .pixel_x(d_x), .pixel_y(d_y)
    );

    vga_sync_gen #(
        .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut_small (
        .clk(clk), .reset_n(rst_s_n), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .frame_tick(s_ft), .pixel_x(s_x), .pixel_y(s_y)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference: c = clk edges since reset; one pixel every two clks, raster order.
    function automatic exp_t model(input int c, input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb, input logic pol);
        exp_t e;
        int ht, vt, k, x, y;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        k  = (c / 2) % (ht * vt);
        x  = k % ht;
        y  = k / ht;
        e.pt  = (c % 2) == 1;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = (x >= hd + hf && x < hd + hf + hsw) ? pol : ~pol;
        e.vs  = (y >= vd + vf && y < vd + vf + vsw) ? pol : ~pol;
        e.von = (x < hd) && (y < vd);
        e.ft  = e.pt && (x == ht - 1) && (y == vt - 1);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_d_n) begin
            cd   = 0;
            d_ok = 1;
        end else if (d_ok) begin
            cd++;
        end
        if (d_ok) qd.push_back(model(cd, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));

        if (!rst_s_n) begin
            cs   = 0;
            s_ok = 1;
        end else if (s_ok) begin
            cs++;
        end
        if (s_ok) qs.push_back(model(cs, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
    end

    always @(negedge clk) begin
        exp_t e;
        if (d_ok) begin
            if (qd.size() == 0) begin
                chk("d.queue", 0, 1);
            end else begin
                e = qd.pop_front();
                chk("d.p_tick", 32'(d_pt), 32'(e.pt));
                chk("d.pixel_x", 32'(d_x), 32'(e.x));
                chk("d.pixel_y", 32'(d_y), 32'(e.y));
                chk("d.hsync", 32'(d_hs), 32'(e.hs));
                chk("d.vsync", 32'(d_vs), 32'(e.vs));
                chk("d.video_on", 32'(d_von), 32'(e.von));
                chk("d.frame_tick", 32'(d_ft), 32'(e.ft));
            end
        end
        if (s_ok) begin
            if (qs.size() == 0) begin
                chk("s.queue", 0, 1);
            end else begin
                e = qs.pop_front();
                chk("s.p_tick", 32'(s_pt), 32'(e.pt));
                chk("s.pixel_x", 32'(s_x), 32'(e.x));
                chk("s.pixel_y", 32'(s_y), 32'(e.y));
                chk("s.hsync", 32'(s_hs), 32'(e.hs));
                chk("s.vsync", 32'(s_vs), 32'(e.vs));
                chk("s.video_on", 32'(s_von), 32'(e.von));
                chk("s.frame_tick", 32'(s_ft), 32'(e.ft));
            end
        end
    end

    initial begin
        int   nft, last, first, nhs;
        logic prev_hs;

        repeat (4) @(negedge clk);
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;

        // Mid-frame reset of the small instance, then three whole frames.
        repeat (150) @(negedge clk);
        rst_s_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_s_n = 1'b1;
        nft     = 0;
        last    = -1;
        first   = -1;
        nhs     = 0;
        prev_hs = s_hs;
        for (int j = 1; j <= 3 * S_FRAME_CLKS; j++) begin
            @(negedge clk);
            if (s_ft) begin
                if (nft == 0) first = j;
                else chk("s.ft_spacing", 32'(j - last), 32'(S_FRAME_CLKS));
                last = j;
                nft++;
            end
            if (s_hs && !prev_hs) nhs++;
            prev_hs = s_hs;
        end
        chk("s.ft_count", 32'(nft), 32'd3);
        chk("s.ft_first", 32'(first), 32'(S_FRAME_CLKS - 1));
        chk("s.hs_pulses", 32'(nhs), 32'(3 * S_VT));

        // Mid-line reset of the full-size instance, then a little over two lines.
        rst_d_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_d_n = 1'b1;
        repeat (3400) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
